tdf_stream_queue: RTL and testbench
===================================

# tdf_stream_queue

Parametrised input-queue stage for TDF page streams using the `_d` / `_e` / `_v` / `_b` token handshake. It sits between a page port and the page's operator logic, the same position as a page's per-stream input queue, and generalises it in three ways: configurable data width, configurable depth, and a configurable back-pressure reserve for producers that see `_b` late. It also adds an occupancy output and sticky overflow detection, which the fixed queue stages lack.

## Interface
- `W`, 16 — token data width in bits, ≥1.
- `DEPTH`, 4 — storage slots; power of two, ≥2.
- `RESERVE`, 1 — slots kept free after `in_b` asserts, to absorb producer `_b` latency; 0 ≤ RESERVE < DEPTH.
- `clock`  input  1  — single clock; all state changes on the rising edge.
- `reset`  input  1  — asynchronous, active-low reset.
- `in_d`  input  W  — incoming token data.
- `in_e`  input  1  — incoming end-of-stream flag, stored with the token.
- `in_v`  input  1  — incoming token valid.
- `in_b`  output  1  — back-pressure to the producer; registered.
- `out_d`  output  W  — head token data.
- `out_e`  output  1  — head token end-of-stream flag.
- `out_v`  output  1  — head token valid (queue non-empty).
- `out_b`  input  1  — consumer back-pressure.
- `level`  output  clog2(DEPTH)+1  — current occupancy, 0..DEPTH.
- `overflow`  output  1  — sticky flag: a token was dropped.

## Operation
- Storage is a circular buffer of DEPTH entries, each W+1 bits ({e, d}), with read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter `count`.
- pop = `out_v & ~out_b`.
- push_ok = `in_v & (count < DEPTH | pop)`. A push while full is accepted only when a pop happens in the same cycle.
- drop = `in_v & ~push_ok`. Drop sets `overflow`, which stays high until reset; the dropped token is discarded.
- A token is accepted on any edge where push_ok holds, regardless of `in_b`. `in_b` is advisory, and RESERVE sizes the tolerance to a producer that ignores it.
- Counter update: count_next = count + push_ok − pop. Simultaneous push and pop leaves count unchanged and advances both pointers.
- `in_b` is registered: in_b ← (count_next ≥ DEPTH − RESERVE). With RESERVE = 0 it asserts only when full.
- `out_d`/`out_e` = entry at the read pointer, first-word-fall-through. `out_v` = (count ≠ 0).
- `out_d`/`out_e` are don't-care while `out_v` = 0, but must not contain X after reset.
- `level` = count.
- `_e` receives no special treatment. An EOS token occupies a slot and is dequeued like data; it does not flush, block, or reset the queue.
- Reset (asynchronous assertion, deassertion synchronised externally): all outputs go to 0 (`out_v`, `out_d`, `out_e`, `in_b`, `level`, `overflow`), and pointers and count clear. Reset mid-stream discards all stored tokens.

## Timing
- Latency: a token pushed into an empty queue at edge N appears with `out_v` = 1 after edge N; the consumer can pop it at edge N+1.
- Throughput: one push and one pop per cycle are sustained at any occupancy, including full (with a same-cycle pop) and empty.
- `in_b` reflects occupancy after the current edge, so it is one cycle behind a combinational full flag.
- A producer that samples `in_b` with up to RESERVE cycles of latency never overflows.
- A pop at count = 1 with no push: `out_v` falls after the same edge.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- `level` and `overflow` update on the same edge as the event that causes them.

## Test plan
All scenarios use W=16, DEPTH=4, RESERVE=1.
- **Reset:** drive reset low mid-run with 2 tokens stored → `out_v`=0, `level`=0, `in_b`=0, `overflow`=0 immediately, without waiting for a clock edge.
- **Fill with consumer stalled:** `out_b`=1; push 0x0001, 0x0002, 0x0003 on consecutive edges → `in_b`=1 after the 3rd edge; push 0x0004 → accepted, `level`=4; push 0x0005 → dropped, `overflow`=1, `level` stays 4.
- **Drain in order:** continue from the previous scenario, release `out_b` → `out_d` reads 0x0001..0x0004 on successive cycles; `in_b` falls after the `level` 3→2 edge; `out_v`=0 after the 4th pop.
- **Full with simultaneous push and pop:** at `level`=4, push 0x00AA with `out_b`=0 → both accepted, `level`=4, `overflow` unchanged; 0x00AA emerges 4th.
- **Streaming wrap:** 20 tokens 0x0000..0x0013 with `out_b`=0 and `in_v`=1 every cycle → output order identical with no gaps, `level` ≤ 1 throughout, `in_b` never asserts.
- **EOS passthrough:** push 0x1234 with `in_e`=1 between data tokens → emerges with `out_e`=1 in sequence; neighbouring tokens have `out_e`=0 and the queue keeps operating.

Source files
------------

// File: rtl/tdf_stream_queue_if.sv
// tdf_stream_queue_if
//   One TDF token stream using the _d/_e/_v/_b handshake.
//   master : token producer. It drives d/e/v and samples b.
//   slave  : token consumer. It samples d/e/v and drives b.
//   d  token data (W bits)
//   e  end-of-stream flag carried with the token
//   v  token valid
//   b  back-pressure from consumer to producer
interface tdf_stream_queue_if #(
  parameter int W = 16
);
  logic [W-1:0] d;
  logic         e;
  logic         v;
  logic         b;

  modport master (output d, e, v, input b);
  modport slave  (input d, e, v, output b);
endinterface

// File: rtl/tdf_stream_queue.sv
// tdf_stream_queue
//   Parametrised first-word-fall-through input queue for a TDF page stream.
//   Tokens ({e, d}) are held in a DEPTH-entry circular buffer.
//   in_b (inPort.b) is a registered occupancy watermark. It asserts once
//   DEPTH-RESERVE slots are in use, so a producer that sees it up to RESERVE
//   cycles late still never overflows. Any token that cannot be stored is
//   discarded and sets a sticky overflow flag.
//
//   Ports:
//     clock     rising-edge clock
//     reset     asynchronous, active-low reset
//     inPort    slave side of the producer stream (d/e/v in, b out)
//     outPort   master side toward operator logic (d/e/v out, b in)
//     level     current occupancy, 0..DEPTH
//     overflow  sticky: a token was dropped since reset
module tdf_stream_queue #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int RESERVE = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  tdf_stream_queue_if.slave        inPort,
  tdf_stream_queue_if.master       outPort,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] HI_WM    = LW'(DEPTH - RESERVE);

  typedef struct packed {
    logic         e;
    logic [W-1:0] d;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rdPtr, wrPtr;
  logic [LW-1:0]   count, countNext;
  logic            inBReg;
  logic            ovfReg;

  logic            full;
  logic            pop;
  logic            pushOk;
  logic            drop;
  entry_t          head;

  assign full   = (count == FULL_LVL);
  assign pop    = outPort.v & ~outPort.b;
  // A full queue still takes a token when the head leaves on the same edge.
  assign pushOk = inPort.v & (~full | pop);
  assign drop   = inPort.v & ~pushOk;

  always_comb begin
    countNext = count;
    case ({pushOk, pop})
      2'b10:   countNext = count + LW'(1);
      2'b01:   countNext = count - LW'(1);
      default: countNext = count;
    endcase
  end

  // Storage is cleared on reset so the head output is never X.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pushOk) begin
      mem[wrPtr] <= '{e: inPort.e, d: inPort.d};
    end
  end

  // DEPTH is a power of two, so the pointers wrap through natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      inBReg <= 1'b0;
      ovfReg <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (pop)    rdPtr <= rdPtr + AW'(1);
      count  <= countNext;
      // The watermark looks at post-edge occupancy, one cycle behind a comb full.
      inBReg <= (countNext >= HI_WM);
      if (drop) ovfReg <= 1'b1;
    end
  end

  assign head      = mem[rdPtr];
  assign outPort.d = head.d;
  assign outPort.e = head.e;
  assign outPort.v = (count != '0);
  assign inPort.b  = inBReg;
  assign level     = count;
  assign overflow  = ovfReg;
endmodule

// File: tb/tb_tdf_stream_queue.sv
module tb_tdf_stream_queue;
  localparam int W = 16;
  localparam int DEPTH = 4;
  localparam int RESERVE = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] level;
  logic       overflow;

  tdf_stream_queue_if #(.W(W)) inIf ();
  tdf_stream_queue_if #(.W(W)) outIf ();

  tdf_stream_queue #(.W(W), .DEPTH(DEPTH), .RESERVE(RESERVE)) dut (
    .clock    (clock),
    .reset    (reset),
    .inPort   (inIf),
    .outPort  (outIf),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        inV;
    logic        inE;
    logic [15:0] inD;
    logic        outB;
    logic        eV;
    logic [15:0] eD;
    logic        eE;
    logic [2:0]  eLvl;
    logic        eInB;
    logic        eOvf;
  } vec_t;

  vec_t vecs[$];
  int   nCmp = 0;
  int   nBad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [15:0] d, input logic b);
    inIf.v  = v;
    inIf.e  = e;
    inIf.d  = d;
    outIf.b = b;
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    // Fill with consumer stalled; 0x0005 hits a full queue and is dropped.
    vecs.push_back('{1, 0, 16'h0001, 1,  1, 16'h0001, 0, 3'd1, 0, 0});
    vecs.push_back('{1, 0, 16'h0002, 1,  1, 16'h0001, 0, 3'd2, 0, 0});
    vecs.push_back('{1, 0, 16'h0003, 1,  1, 16'h0001, 0, 3'd3, 1, 0});
    vecs.push_back('{1, 0, 16'h0004, 1,  1, 16'h0001, 0, 3'd4, 1, 0});
    vecs.push_back('{1, 0, 16'h0005, 1,  1, 16'h0001, 0, 3'd4, 1, 1});
    // Drain in order.
    vecs.push_back('{0, 0, 16'h0000, 0,  1, 16'h0002, 0, 3'd3, 1, 1});
    vecs.push_back('{0, 0, 16'h0000, 0,  1, 16'h0003, 0, 3'd2, 0, 1});
    vecs.push_back('{0, 0, 16'h0000, 0,  1, 16'h0004, 0, 3'd1, 0, 1});
    vecs.push_back('{0, 0, 16'h0000, 0,  0, 16'h0000, 0, 3'd0, 0, 1});
    // Refill, then push while full with a same-cycle pop.
    vecs.push_back('{1, 0, 16'h0010, 1,  1, 16'h0010, 0, 3'd1, 0, 1});
    vecs.push_back('{1, 0, 16'h0011, 1,  1, 16'h0010, 0, 3'd2, 0, 1});
    vecs.push_back('{1, 0, 16'h0012, 1,  1, 16'h0010, 0, 3'd3, 1, 1});
    vecs.push_back('{1, 0, 16'h0013, 1,  1, 16'h0010, 0, 3'd4, 1, 1});
    vecs.push_back('{1, 0, 16'h00AA, 0,  1, 16'h0011, 0, 3'd4, 1, 1});
    vecs.push_back('{0, 0, 16'h0000, 0,  1, 16'h0012, 0, 3'd3, 1, 1});
    vecs.push_back('{0, 0, 16'h0000, 0,  1, 16'h0013, 0, 3'd2, 0, 1});
    vecs.push_back('{0, 0, 16'h0000, 0,  1, 16'h00AA, 0, 3'd1, 0, 1});
    vecs.push_back('{0, 0, 16'h0000, 0,  0, 16'h0000, 0, 3'd0, 0, 1});
    // EOS token between data tokens.
    vecs.push_back('{1, 0, 16'h0100, 0,  1, 16'h0100, 0, 3'd1, 0, 1});
    vecs.push_back('{1, 1, 16'h1234, 0,  1, 16'h1234, 1, 3'd1, 0, 1});
    vecs.push_back('{1, 0, 16'h0101, 0,  1, 16'h0101, 0, 3'd1, 0, 1});
    vecs.push_back('{0, 0, 16'h0000, 0,  0, 16'h0000, 0, 3'd0, 0, 1});

    // Power-on reset state.
    #12;
    check("rst_out_v", outIf.v, 1'b0);
    check("rst_out_d", outIf.d, 16'h0);
    check("rst_out_e", outIf.e, 1'b0);
    check("rst_in_b", inIf.b, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Table vectors: inputs applied at negedge, results sampled just after posedge.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].inV, vecs[i].inE, vecs[i].inD, vecs[i].outB);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_out_v", i), outIf.v, vecs[i].eV);
      if (vecs[i].eV) begin
        check($sformatf("v%0d_out_d", i), outIf.d, vecs[i].eD);
        check($sformatf("v%0d_out_e", i), outIf.e, vecs[i].eE);
      end
      check($sformatf("v%0d_level", i), level, vecs[i].eLvl);
      check($sformatf("v%0d_in_b", i), inIf.b, vecs[i].eInB);
      check($sformatf("v%0d_overflow", i), overflow, vecs[i].eOvf);
    end

    // Streaming through the wrap point: one token in and one out each cycle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, 16'(i), 1'b0);
      @(posedge clock);
      #1;
      check($sformatf("s%0d_out_v", i), outIf.v, 1'b1);
      check($sformatf("s%0d_out_d", i), outIf.d, 16'(i));
      check($sformatf("s%0d_level", i), level, 3'd1);
      check($sformatf("s%0d_in_b", i), inIf.b, 1'b0);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    @(posedge clock);
    #1;
    check("s_end_out_v", outIf.v, 1'b0);
    check("s_end_level", level, 3'd0);

    // Mid-run reset with two tokens stored must clear without a clock edge.
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h0055, 1'b1);
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h0066, 1'b1);
    @(negedge clock);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    check("pre_rst_level", level, 3'd2);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_v", outIf.v, 1'b0);
    check("mid_rst_level", level, 3'd0);
    check("mid_rst_in_b", inIf.b, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_out_d", outIf.d, 16'h0);
    check("mid_rst_out_e", outIf.e, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    // After reset the queue accepts a fresh token normally.
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h0077, 1'b0);
    @(posedge clock);
    #1;
    check("post_rst_out_d", outIf.d, 16'h0077);
    check("post_rst_level", level, 3'd1);
    @(negedge clock);
    drive(1'b0, 1'b0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
